// File: rtl/alu_mult_pkg.sv
// Shared definitions for the ALU sequential multiplier: state encoding and
// iteration/counter sizing.
package alu_mult_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int ITERS         = WIDTH_DEFAULT;
    localparam int CNT_W         = $clog2(WIDTH_DEFAULT) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiplication_signed_32.sv
// Sequential signed WIDTH x WIDTH -> 2*WIDTH multiplier: radix-2 shift-add on
// operand magnitudes, then a sign-fixup cycle. MULT_EARLY_ZERO_EN skips CALC for zero operands.
module multiplication_signed_32
    import alu_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     operand1,
    input  logic [WIDTH-1:0]     operand2,
    output logic [2*WIDTH-1:0]   result,
    output logic                 finish,
    output logic                 overflow,
    output logic                 busy
);

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic                 sign;
    logic [CNT_W-1:0]     count;

    logic [WIDTH-1:0]     abs1;
    logic [WIDTH-1:0]     abs2;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   fixed;
    logic                 ovf_next;

    // Magnitudes are unsigned, so negating the most negative value yields 2^(WIDTH-1) exactly.
    always_comb begin
        abs1     = operand1[WIDTH-1] ? -operand1 : operand1;
        abs2     = operand2[WIDTH-1] ? -operand2 : operand2;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{mplier[0]}} & mcand};
        fixed    = sign ? -acc : acc;
        ovf_next = !((&fixed[2*WIDTH-1:WIDTH-1]) || !(|fixed[2*WIDTH-1:WIDTH-1]));
    end

`ifdef MULT_EARLY_ZERO_EN
    logic zero_op;
    assign zero_op = (operand1 == '0) || (operand2 == '0);
`endif

    // NOTE: async reset clears every register, including datapath state, so an
    // aborted operation leaves nothing behind; all state updates use <= only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            sign     <= 1'b0;
            count    <= '0;
            result   <= '0;
            finish   <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= abs1;
                        mplier <= abs2;
                        sign   <= operand1[WIDTH-1] ^ operand2[WIDTH-1];
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
`ifdef MULT_EARLY_ZERO_EN
                        state  <= zero_op ? DONE : CALC;
`else
                        state  <= CALC;
`endif
                    end
                end
                CALC: begin
                    // Shift {carry, acc, mplier} right by one after the conditional add.
                    acc    <= {sum, acc[WIDTH-1:1]};
                    mplier <= {acc[0], mplier[WIDTH-1:1]};
                    count  <= count + 1'b1;
                    if (count == CNT_W'(ITERS - 1))
                        state <= DONE;
                end
                DONE: begin
                    // Two cycles here: publish the result, then hold off start during the finish pulse.
                    if (!finish) begin
                        result   <= fixed;
                        overflow <= ovf_next;
                        finish   <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplication_signed_32.sv
// Self-checking bench for multiplication_signed_32: directed vector table, random
// operands against a plain-arithmetic product model, and handshake corner sequences.
module tb_multiplication_signed_32;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [63:0] result;
    logic        finish;
    logic        overflow;
    logic        busy;

    int vectors;
    int miscompares;

`ifdef MULT_EARLY_ZERO_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif
    localparam int FULL_LAT = 33;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[13];

    multiplication_signed_32 dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .operand1 (operand1),
        .operand2 (operand2),
        .result   (result),
        .finish   (finish),
        .overflow (overflow),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
    endfunction

    function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return (p > 64'sd2147483647) || (p < -64'sd2147483648);
    endfunction

    // Present operands with start for one cycle; returns #1 after the accepting edge (E0).
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        operand1 = a;
        operand2 = b;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Count edges until finish is seen; lat is the edge index relative to E0.
    task automatic wait_finish(input int lat0, output int lat, output logic ok);
        lat = lat0;
        ok  = 1'b0;
        while (lat < 200) begin
            @(posedge clock);
            #1 lat++;
            if (finish) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Count finish pulses over n cycles.
    task automatic count_finishes(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1 if (finish) pulses++;
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input logic exp_ovf);
        int   lat;
        logic ok;
        int   exp_lat;
        exp_lat = (a == 0 || b == 0) ? ZERO_LAT : FULL_LAT;
        launch(a, b);
        wait_finish(0, lat, ok);
        check({name, "_timeout"}, 64'(ok), 64'd1);
        check({name, "_result"}, result, exp_res);
        check({name, "_ovf"}, 64'(overflow), 64'(exp_ovf));
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_busy_at_finish"}, 64'(busy), 64'd1);
        @(posedge clock);
        #1;
        check({name, "_finish_width"}, 64'(finish), 64'd0);
        check({name, "_busy_drop"}, 64'(busy), 64'd0);
        check({name, "_result_held"}, result, exp_res);
    endtask

    initial begin
        int   lat;
        int   pulses;
        logic ok;
        logic [31:0] a, b;

        vectors     = 0;
        miscompares = 0;

        tbl[0]  = '{32'h1000_0000, 32'h0000_0010, 64'h0000_0001_0000_0000, 1'b1};
        tbl[1]  = '{32'd2222,      32'd2,         64'd4444,                1'b0};
        tbl[2]  = '{32'd200,       32'd0,         64'd0,                   1'b0};
        tbl[3]  = '{-32'sd42,      32'd5,         64'hFFFF_FFFF_FFFF_FF2E, 1'b0};
        tbl[4]  = '{-32'sd42,      -32'sd5,       64'd210,                 1'b0};
        tbl[5]  = '{32'd42,        -32'sd5,       64'hFFFF_FFFF_FFFF_FF2E, 1'b0};
        tbl[6]  = '{32'd42,        32'd5,         64'd210,                 1'b0};
        tbl[7]  = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1};
        tbl[8]  = '{32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000, 1'b0};
        tbl[9]  = '{32'd0,         -32'sd7,       64'd0,                   1'b0};
        tbl[10] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1};
        tbl[11] = '{-32'sd1,       -32'sd1,       64'd1,                   1'b0};
        tbl[12] = '{-32'sd1,       32'h8000_0000, 64'h0000_0000_8000_0000, 1'b1};

        reset_n  = 1'b0;
        start    = 1'b0;
        operand1 = '0;
        operand2 = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_result", result, 64'd0);
        check("reset_finish", 64'(finish), 64'd0);
        check("reset_ovf", 64'(overflow), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp_res, tbl[i].exp_ovf);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 5)
                1: a = a >> 16;
                2: b = $signed(b) >>> 20;
                3: a = (i % 2 == 0) ? 32'h8000_0000 : 32'h0;
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), a, b, ref_prod(a, b), ref_ovf(a, b));
        end

        // Second start with new operands at E10 must be ignored.
        launch(32'd7, 32'd9);
        repeat (9) @(posedge clock);
        @(negedge clock);
        start    = 1'b1;
        operand1 = 32'd123;
        operand2 = -32'sd1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_finish(10, lat, ok);
        check("midop_timeout", 64'(ok), 64'd1);
        check("midop_result", result, 64'd63);
        check("midop_latency", 64'(lat), 64'd33);
        count_finishes(45, pulses);
        check("midop_single_finish", 64'(pulses), 64'd0);

        // Start held high for five cycles, then a start during the finish cycle.
        @(negedge clock);
        operand1 = -32'sd3;
        operand2 = 32'd11;
        start    = 1'b1;
        repeat (5) @(posedge clock);
        #1 start = 1'b0;
        wait_finish(4, lat, ok);
        check("held_timeout", 64'(ok), 64'd1);
        check("held_result", result, 64'hFFFF_FFFF_FFFF_FFDF);
        check("held_latency", 64'(lat), 64'd33);
        operand1 = 32'd5;
        operand2 = 32'd5;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        check("start_in_finish_busy", 64'(busy), 64'd0);
        count_finishes(45, pulses);
        check("start_in_finish_ignored", 64'(pulses), 64'd0);
        check("start_in_finish_result", result, 64'hFFFF_FFFF_FFFF_FFDF);

        // Reset at E15 aborts the operation with no finish.
        launch(32'd1000, 32'd1000);
        repeat (15) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("abort_result", result, 64'd0);
        check("abort_finish", 64'(finish), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ovf", 64'(overflow), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        count_finishes(40, pulses);
        check("abort_no_finish", 64'(pulses), 64'd0);
        run_op("after_abort", -32'sd12345, 32'd6789, ref_prod(-32'sd12345, 32'd6789), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multiplication_signed_32.md
Name: multiplication_signed_32

Overview:
- Sequential signed 32x32 to 64-bit multiplier; the inverse operation of the existing signed divider.
- Uses the same start/finish pulse handshake and the same 64-bit result bus convention.
- Sits beside the divider inside the ALU datapath.
- Radix-2 shift-add on operand magnitudes, followed by a sign-fixup cycle.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH. Only 32 is verified.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- operand1  input  32  multiplicand, two's complement.
- operand2  input  32  multiplier, two's complement.
- result  output  64  signed product; holds its value until the next finish.
- finish  output  1  one-cycle pulse; result is valid while it is high.
- overflow  output  1  product does not fit in signed 32 bits; valid with finish and held with result.
- busy  output  1  high from the cycle after start is accepted through the finish cycle.

Behaviour:
- Reset (async assert, sync release): state=IDLE; result=0, finish=0, overflow=0, busy=0; counter and internal registers cleared.
- States:
  - IDLE to CALC: on start=1 at edge E0. Latch |operand1| into mcand and |operand2| into mplier as unsigned 32-bit values. Latch sign = operand1[31]^operand2[31]. Clear acc (64 bits). count=0.
  - CALC: each edge, if mplier[0], add mcand into acc[63:32] with carry kept in a 65-bit sum. Then shift {carry,acc,mplier} right by 1 and increment count. After the 32nd CALC edge (E32), go to DONE.
  - DONE (edge E33): result = sign ? -acc : acc. overflow = (result[63:31] not all equal). finish=1 for exactly this one cycle. Return to IDLE; busy drops at E34.
- Latency: start sampled at E0, finish high between E33 and E34, i.e. 33 cycles. Fixed, independent of operand values (unless MULT_EARLY_ZERO_EN).
- Operands are sampled only at E0; later changes are ignored.
- start while busy is ignored (no queueing).
- start in the same cycle as the finish pulse is ignored, because the state is DONE, not IDLE.
- start held high for several cycles starts exactly one operation. A new op needs start sampled in IDLE.
- Magnitudes are unsigned 32 bits, so -2^31 is handled exactly: (-2^31)*(-2^31) = 2^62.
- Zero operand yields result=0, overflow=0, and sign is irrelevant (0 negated is 0).
- reset_n low mid-operation aborts immediately to reset values; no finish is emitted.
- finish is never asserted twice per accepted start.

Optional Feature:
- Macro: MULT_EARLY_ZERO_EN.
- Defined: in IDLE, if start=1 and (operand1==0 or operand2==0), skip CALC and go directly to DONE. result=0 and finish is high at E1, so latency is 1 cycle.
- Undefined: zero operands take the full 33-cycle path.
- The result value is identical either way.

Decomposition:
- Package alu_mult_pkg holds:
  - the state enum (IDLE, CALC, DONE) as 2-bit encoded values;
  - the WIDTH default;
  - the counter width CNT_W = $clog2(WIDTH)+1;
  - the iteration constant ITERS = WIDTH.
- No sub-module required; the magnitude/negate logic is inline combinational.
- A shared two's-complement abs helper can be factored later together with the divider.

Test Plan:
- 0x10000000 * 0x10 -> result=64'h0000_0001_0000_0000, overflow=1, finish exactly 33 cycles after the start edge, one cycle wide.
- 2222 * 2 -> result=4444, overflow=0. Then 200 * 0 -> result=0, overflow=0, with latency 33 (feature off) or 1 (MULT_EARLY_ZERO_EN).
- Signs:
  - -42*5 -> 64'hFFFF_FFFF_FFFF_FF2E
  - -42*-5 -> 210
  - 42*-5 -> 64'hFFFF_FFFF_FFFF_FF2E
  - 42*5 -> 210
  - all with overflow=0.
- 0x80000000 * 0x80000000 -> 64'h4000_0000_0000_0000, overflow=1. 0x80000000 * 1 -> 64'hFFFF_FFFF_8000_0000, overflow=0.
- Second start pulse and changed operands at E10 mid-operation -> ignored; the first result is unchanged and only one finish is produced.
- reset_n low at E15 of an op -> result=0, finish=0, busy=0 immediately. A new start after release completes normally with a correct product.
